// File: rtl/uart_rx.sv
// 8N1 UART receiver with a one-byte holding register,
// read handshake, framing-error and overrun pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Rx_Serial,
  input  logic       i_Rx_Read,
  output logic [7:0] o_Rx_Byte,
  output logic       o_Rx_DV,
  output logic       o_Rx_Ready,
  output logic       o_Frame_Err,
  output logic       o_Overrun,
  output logic       o_Rx_Active
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    CLEANUP = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      byte_q, byte_d;
  logic            ready_q, ready_d;
  logic            active_q, active_d;
  logic            dv_q, dv_d;
  logic            ferr_q, ferr_d;
  logic            ovr_q, ovr_d;
  logic            rx_meta_q, rx_s_q;

  // Line idles high, so the synchronizer resets to 1.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= i_Rx_Serial;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      byte_q   <= '0;
      ready_q  <= 1'b0;
      active_q <= 1'b0;
      dv_q     <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      byte_q   <= byte_d;
      ready_q  <= ready_d;
      active_q <= active_d;
      dv_q     <= dv_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    byte_d   = byte_q;
    ready_d  = ready_q;
    active_d = active_q;
    dv_d     = 1'b0;
    ferr_d   = 1'b0;
    ovr_d    = 1'b0;

    if (i_Rx_Read && ready_q)
      ready_d = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
        if (!rx_s_q) begin
          state_d  = START;
          active_d = 1'b1;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_s_q) begin
            state_d = DATA;
          end else begin
            state_d  = IDLE;
            active_d = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s_q;
          if (idx_q == 3'd7)
            state_d = STOP;
          else
            idx_d = idx_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = CLEANUP;
          // A same-cycle read frees the slot for the new byte.
          if (rx_s_q) begin
            byte_d  = shift_q;
            dv_d    = 1'b1;
            ovr_d   = ready_q && !i_Rx_Read;
            ready_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CLEANUP: begin
        state_d  = IDLE;
        active_d = 1'b0;
      end
      default: begin
        state_d  = IDLE;
        cnt_d    = '0;
        idx_d    = '0;
        active_d = 1'b0;
      end
    endcase
  end

  assign o_Rx_Byte   = byte_q;
  assign o_Rx_DV     = dv_q;
  assign o_Rx_Ready  = ready_q;
  assign o_Frame_Err = ferr_q;
  assign o_Overrun   = ovr_q;
  assign o_Rx_Active = active_q;

endmodule
